debug_sequencer: RTL and testbench

- Host-side controller for the MIPS debug path.
- Takes command bytes from the UART receiver and gates the pipeline clock enable (step / run / halt / pipeline reset).
- Drives the 6-bit probe selector into the debug probe mux and serialises the selected 32-bit value back to the UART transmitter, LSB first.
- Replaces the byte-coded pseudo-clock with a proper clock-enable scheme on the single system clock.

---
 rtl/dbg_pkg.sv | 45 ++++
 rtl/debug_sequencer_if.sv | 18 +
 rtl/dbg_tx_serializer.sv | 44 ++++
 rtl/debug_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_debug_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the MIPS debug sequencer: command op codes, FSM states,
// decoded command kinds and default reply constants.
package dbg_pkg;

    localparam logic [5:0] OP_STEP   = 6'h3F;
    localparam logic [5:0] OP_RUN    = 6'h38;
    localparam logic [5:0] OP_HALT   = 6'h39;
    localparam logic [5:0] OP_PRESET = 6'h3A;
    localparam logic [5:0] OP_RDCYC  = 6'h3B;

    localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [7:0]  DEF_ACK_ERR    = 8'hEE;
    localparam logic [7:0]  DEF_ACK_IHALT  = 8'hF0;
    localparam logic [7:0]  DEF_ACK_HHALT  = 8'hF1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_RUN,
        ST_SEND
    } state_t;

    typedef enum logic [2:0] {
        CMD_READ,
        CMD_STEP,
        CMD_RUN,
        CMD_HALT,
        CMD_PRESET,
        CMD_RDCYC,
        CMD_RSVD
    } cmd_kind_t;

    // Every op in 6'h38..6'h3F not named above is reserved; everything below is a probe read.
    function automatic cmd_kind_t decode_op(input logic [5:0] op);
        if (op == OP_STEP)        return CMD_STEP;
        else if (op == OP_RUN)    return CMD_RUN;
        else if (op == OP_HALT)   return CMD_HALT;
        else if (op == OP_PRESET) return CMD_PRESET;
        else if (op == OP_RDCYC)  return CMD_RDCYC;
        else if (op >= 6'h38)     return CMD_RSVD;
        else                      return CMD_READ;
    endfunction

endpackage

// File: rtl/debug_sequencer_if.sv
// UART-side byte streams of the debug sequencer: receive pulse and transmit valid/ready.
interface debug_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/dbg_tx_serializer.sv
// Reply serialiser: holds up to four bytes and hands them to the UART transmitter
// LSB first over a valid/ready handshake, pulsing o_done on the last transfer.
module dbg_tx_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_value,
    input  logic [1:0]  i_last,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic [1:0]  r_last;
    logic        r_valid;
    logic        w_xfer;

    assign w_xfer  = r_valid & i_ready;
    assign o_done  = w_xfer & (r_cnt == r_last);
    assign o_data  = r_shift[7:0];
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= 32'h0;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_value;
            r_cnt   <= 2'd0;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_shift <= {8'h00, r_shift[31:8]};
            r_cnt   <= r_cnt + 2'd1;
            r_valid <= (r_cnt != r_last);
        end
    end

endmodule

// File: rtl/debug_sequencer.sv
// Host-side debug controller: decodes UART command bytes, gates the pipeline clock
// enable for step/run/halt, and streams probe or cycle-count values back to the host.
module debug_sequencer
    import dbg_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = DEF_HALT_INSTR,
    parameter logic [7:0]  ACK_ERR    = DEF_ACK_ERR,
    parameter logic [7:0]  ACK_IHALT  = DEF_ACK_IHALT,
    parameter logic [7:0]  ACK_HHALT  = DEF_ACK_HHALT
) (
    input  logic               clk,
    input  logic               reset,
    debug_sequencer_if.slave   uart,
    output logic [5:0]         probe_sel,
    input  logic [31:0]        probe_data,
    input  logic [31:0]        instr_if,
    output logic               pipe_en,
    output logic               pipe_reset,
    output logic               running,
    output logic [31:0]        cycle_count,
    output logic               rx_overrun
);

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [5:0]  r_probe_sel;
    logic        r_step_en;
    logic        r_pipe_reset;
    logic        r_running;
    logic [31:0] r_cycle_count;
    logic        r_rx_overrun;

    cmd_kind_t   w_rx_kind;
    logic        w_host_halt;
    logic        w_instr_halt;
    logic        w_pipe_en;
    logic        w_ld;
    logic [31:0] w_ld_value;
    logic [1:0]  w_ld_last;
    logic        w_tx_done;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;

    assign w_rx_kind    = decode_op(uart.rx_data[5:0]);
    assign w_host_halt  = r_running & uart.rx_valid & (w_rx_kind == CMD_HALT);
    assign w_instr_halt = r_running & (instr_if == HALT_INSTR);
    // A host HALT must stop the pipeline in the very cycle it arrives, so RUN gating is combinational.
    assign w_pipe_en    = r_step_en | (r_running & ~w_instr_halt & ~w_host_halt);

    assign pipe_en       = w_pipe_en;
    assign probe_sel     = r_probe_sel;
    assign pipe_reset    = r_pipe_reset;
    assign running       = r_running;
    assign cycle_count   = r_cycle_count;
    assign rx_overrun    = r_rx_overrun;
    assign uart.tx_data  = w_tx_data;
    assign uart.tx_valid = w_tx_valid;

    always_comb begin
        w_ld       = 1'b0;
        w_ld_value = 32'h0;
        w_ld_last  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (uart.rx_valid) begin
                    case (w_rx_kind)
                        CMD_PRESET: begin
                            w_ld       = 1'b1;
                            w_ld_value = {24'h0, uart.rx_data};
                        end
                        CMD_RDCYC: begin
                            w_ld       = 1'b1;
                            w_ld_value = r_cycle_count;
                            w_ld_last  = uart.rx_data[7:6];
                        end
                        CMD_HALT: begin
                            w_ld       = 1'b1;
                            w_ld_value = {24'h0, ACK_HHALT};
                        end
                        CMD_RSVD: begin
                            w_ld       = 1'b1;
                            w_ld_value = {24'h0, ACK_ERR};
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                w_ld       = 1'b1;
                w_ld_value = probe_data;
                w_ld_last  = r_cmd[7:6];
            end
            ST_STEP: begin
                w_ld       = 1'b1;
                w_ld_value = {24'h0, r_cmd};
            end
            ST_RUN: begin
                if (w_host_halt) begin
                    w_ld       = 1'b1;
                    w_ld_value = {24'h0, ACK_HHALT};
                end else if (w_instr_halt) begin
                    w_ld       = 1'b1;
                    w_ld_value = {24'h0, ACK_IHALT};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd         <= 8'h0;
            r_probe_sel   <= 6'h0;
            r_step_en     <= 1'b0;
            r_pipe_reset  <= 1'b0;
            r_running     <= 1'b0;
            r_cycle_count <= 32'h0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_step_en    <= 1'b0;
            r_pipe_reset <= 1'b0;
            if (w_pipe_en) r_cycle_count <= r_cycle_count + 32'd1;
            case (r_state)
                ST_IDLE: begin
                    if (uart.rx_valid) begin
                        r_cmd <= uart.rx_data;
                        case (w_rx_kind)
                            CMD_READ: begin
                                r_probe_sel <= uart.rx_data[5:0];
                                r_state     <= ST_LOAD;
                            end
                            CMD_STEP: begin
                                r_step_en <= 1'b1;
                                r_state   <= ST_STEP;
                            end
                            CMD_RUN: begin
                                r_running <= 1'b1;
                                r_state   <= ST_RUN;
                            end
                            CMD_PRESET: begin
                                r_pipe_reset  <= 1'b1;
                                r_cycle_count <= 32'h0;
                                r_state       <= ST_SEND;
                            end
                            default: r_state <= ST_SEND;
                        endcase
                    end
                end
                ST_LOAD, ST_STEP: begin
                    if (uart.rx_valid) r_rx_overrun <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_RUN: begin
                    if (uart.rx_valid && w_rx_kind != CMD_HALT) r_rx_overrun <= 1'b1;
                    if (w_host_halt || w_instr_halt) begin
                        r_running <= 1'b0;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart.rx_valid) r_rx_overrun <= 1'b1;
                    if (w_tx_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dbg_tx_serializer u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_ld),
        .i_value (w_ld_value),
        .i_last  (w_ld_last),
        .i_ready (uart.tx_ready),
        .o_data  (w_tx_data),
        .o_valid (w_tx_valid),
        .o_done  (w_tx_done)
    );

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: expected reply bytes are queued as commands
// are issued and popped as the transmitter handshakes them out.
module tb_debug_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  probe_sel;
    logic [31:0] probe_data;
    logic [31:0] instr_if;
    logic        pipe_en;
    logic        pipe_reset;
    logic        running;
    logic [31:0] cycle_count;
    logic        rx_overrun;

    debug_sequencer_if u_if ();

    debug_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .uart        (u_if),
        .probe_sel   (probe_sel),
        .probe_data  (probe_data),
        .instr_if    (instr_if),
        .pipe_en     (pipe_en),
        .pipe_reset  (pipe_reset),
        .running     (running),
        .cycle_count (cycle_count),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe_model(input logic [5:0] sel);
        if (sel == 6'h0A) return 32'h1234_5678;
        return {26'h0, sel} ^ 32'hA5A5_0000;
    endfunction

    assign probe_data = probe_model(probe_sel);

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          pe_cnt = 0;
    int          pe_run = 0;
    int          pe_max = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the monitor looks 1ns later, so it sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        #1;
        if (!reset && u_if.tx_valid && u_if.tx_ready) begin
            chk("tx_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("tx_byte", u_if.tx_data, exp_q.pop_front());
        end
        if (pipe_en) begin
            pe_cnt++;
            pe_run++;
            if (pe_run > pe_max) pe_max = pe_run;
        end else begin
            pe_run = 0;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(v >> (8 * i)));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !u_if.tx_valid) break;
            n++;
        end
        chk("idle_timeout", (n < 200), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_valid"},   u_if.tx_valid, 0);
        chk({tag, "_tx_data"},    u_if.tx_data, 0);
        chk({tag, "_probe_sel"},  probe_sel, 0);
        chk({tag, "_pipe_en"},    pipe_en, 0);
        chk({tag, "_pipe_reset"}, pipe_reset, 0);
        chk({tag, "_running"},    running, 0);
        chk({tag, "_cycle_cnt"},  cycle_count, 0);
        chk({tag, "_overrun"},    rx_overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.tx_ready = 1'b1;
        instr_if      = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;

        // Probe read, 4 bytes from sel 0A, then a 1-byte read of sel 05
        push_word(32'h1234_5678, 4);
        send_cmd(8'hCA);
        chk("probe_sel_0A", probe_sel, 6'h0A);
        wait_idle();
        push_word(probe_model(6'h05), 1);
        send_cmd(8'h05);
        chk("probe_sel_05", probe_sel, 6'h05);
        wait_idle();

        // Two steps
        pe_cnt = 0; pe_max = 0;
        exp_q.push_back(8'h3F);
        send_cmd(8'h3F);
        wait_idle();
        exp_q.push_back(8'h3F);
        send_cmd(8'h3F);
        wait_idle();
        chk("step_pulses", pe_cnt, 2);
        chk("step_pulse_len", pe_max, 1);
        chk("step_cycles", cycle_count, 2);

        // Pipeline reset
        exp_q.push_back(8'h3A);
        send_cmd(8'h3A);
        chk("preset_pulse", pipe_reset, 1);
        chk("preset_count", cycle_count, 0);
        @(negedge clk);
        chk("preset_one_cycle", pipe_reset, 0);
        wait_idle();

        // Run ended by the halt instruction after 10 cycles
        pe_cnt = 0;
        exp_q.push_back(8'hF0);
        send_cmd(8'h38);
        chk("run_running", running, 1);
        repeat (10) @(negedge clk);
        instr_if = 32'hFFFF_FFFF;
        #2;
        chk("ihalt_pipe_en", pipe_en, 0);
        @(negedge clk);
        instr_if = 32'h0;
        #2;
        chk("ihalt_running", running, 0);
        chk("ihalt_tx_valid", u_if.tx_valid, 1);
        wait_idle();
        chk("ihalt_pe_cnt", pe_cnt, 10);
        chk("ihalt_cycles", cycle_count, 10);

        // Run ended by host HALT colliding with the halt instruction
        pe_cnt = 0;
        exp_q.push_back(8'hF1);
        send_cmd(8'h38);
        repeat (5) @(negedge clk);
        instr_if      = 32'hFFFF_FFFF;
        u_if.rx_data  = 8'h39;
        u_if.rx_valid = 1'b1;
        #2;
        chk("hhalt_pipe_en", pipe_en, 0);
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        instr_if      = 32'h0;
        #2;
        chk("hhalt_running", running, 0);
        wait_idle();
        chk("hhalt_pe_cnt", pe_cnt, 5);
        chk("hhalt_cycles", cycle_count, 15);
        chk("hhalt_no_overrun", rx_overrun, 0);

        // HALT while idle and a reserved op
        exp_q.push_back(8'hF1);
        send_cmd(8'h39);
        wait_idle();
        exp_q.push_back(8'hEE);
        send_cmd(8'h3C);
        wait_idle();
        chk("rsvd_no_overrun", rx_overrun, 0);

        // Backpressure on a 2-byte cycle read with a byte arriving mid-send
        u_if.tx_ready = 1'b0;
        push_word(32'd15, 2);
        send_cmd(8'h7B);
        for (int i = 0; i < 5; i++) begin
            chk("bp_tx_valid", u_if.tx_valid, 1);
            chk("bp_tx_data", u_if.tx_data, 8'h0F);
            u_if.rx_data  = 8'h3F;
            u_if.rx_valid = (i == 2);
            @(negedge clk);
        end
        u_if.rx_valid = 1'b0;
        u_if.tx_ready = 1'b1;
        wait_idle();
        chk("bp_overrun", rx_overrun, 1);
        chk("bp_dropped_step", cycle_count, 15);

        // Reset during byte 2 of a 4-byte reply
        u_if.tx_ready = 1'b0;
        push_word(32'd15, 4);
        send_cmd(8'hFB);
        chk("rs_byte1", u_if.tx_data, 8'h0F);
        u_if.tx_ready = 1'b1;
        @(negedge clk);
        u_if.tx_ready = 1'b0;
        chk("rs_byte2_valid", u_if.tx_valid, 1);
        chk("rs_remaining", exp_q.size(), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk_all_zero("midrst");
        u_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx_valid", u_if.tx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
